// File: rtl/instruction_loader_pkg.sv
// instruction_loader_pkg: shared byte size, HALT encoding and loader state encodings
package instruction_loader_pkg;

    localparam int BYTE_SIZE = 8;

    localparam logic [31:0] INSTRUCTION_HALT = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_RECEIVE = 3'd2,
        ST_WRITE   = 3'd3,
        ST_DONE    = 3'd4,
        ST_ERROR   = 3'd5
    } state_t;

endpackage

// File: rtl/instruction_loader_word_assembler.sv
// instruction_loader_word_assembler: big-endian byte shift register with a wrapping byte counter
module instruction_loader_word_assembler
    import instruction_loader_pkg::*;
#(
    parameter int WORD_SIZE_IN_BYTES = 4
) (
    input  logic                                  i_clk,
    input  logic                                  i_reset,
    input  logic                                  i_shift,
    input  logic                                  i_zero,
    input  logic [BYTE_SIZE-1:0]                  i_byte,
    output logic [WORD_SIZE_IN_BYTES*BYTE_SIZE-1:0] o_word,
    output logic                                  o_last
);

    localparam int WW = WORD_SIZE_IN_BYTES * BYTE_SIZE;
    localparam int CW = (WORD_SIZE_IN_BYTES > 1) ? $clog2(WORD_SIZE_IN_BYTES) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [WW-1:0] word_q, word_d;

    assign o_word = word_q;
    assign o_last = (cnt_q == CW'(WORD_SIZE_IN_BYTES - 1));

    // Zero wins over shift; the first byte shifted in ends up as the MSB
    always_comb begin
        cnt_d  = cnt_q;
        word_d = word_q;
        if (i_zero) begin
            cnt_d  = '0;
            word_d = '0;
        end else if (i_shift) begin
            cnt_d  = o_last ? '0 : cnt_q + 1'b1;
            word_d = {word_q[WW-BYTE_SIZE-1:0], i_byte};
        end
    end

    // Counter and shift register flops
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/instruction_loader.sv
// instruction_loader: downloads a byte stream into instruction memory, stopping on HALT or overflow
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int WORD_SIZE_IN_BYTES = 4,
    parameter int MEM_SIZE_IN_WORDS  = 10
) (
    input  logic                                          i_clk,
    input  logic                                          i_reset,
    input  logic                                          i_start,
    input  logic                                          i_byte_valid,
    input  logic [BYTE_SIZE-1:0]                          i_byte,
    output logic                                          o_byte_ready,
    output logic                                          o_clear,
    output logic                                          o_instruction_write,
    output logic [WORD_SIZE_IN_BYTES*BYTE_SIZE-1:0]       o_instruction,
    output logic [$clog2(MEM_SIZE_IN_WORDS+1)-1:0]        o_word_count,
    output logic                                          o_done,
    output logic                                          o_overflow
);

    localparam int WW = WORD_SIZE_IN_BYTES * BYTE_SIZE;
    localparam int CW = $clog2(MEM_SIZE_IN_WORDS + 1);

    state_t        state_q, state_d;
    logic [CW-1:0] word_count_q, word_count_d, word_count_inc;
    logic [WW-1:0] word;
    logic          last_byte;
    logic          shift;

    assign shift          = (state_q == ST_RECEIVE) && i_byte_valid;
    assign word_count_inc = word_count_q + 1'b1;
    assign o_instruction  = word;
    assign o_word_count   = word_count_q;

    instruction_loader_word_assembler #(
        .WORD_SIZE_IN_BYTES(WORD_SIZE_IN_BYTES)
    ) u_word_assembler (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .i_shift(shift),
        .i_zero (state_q == ST_CLEAR),
        .i_byte (i_byte),
        .o_word (word),
        .o_last (last_byte)
    );

    // State and word counter registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= ST_IDLE;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            word_count_q <= word_count_d;
        end
    end

    // Next state; HALT takes priority over a full memory, and start is only honoured when not loading
    always_comb begin
        state_d      = state_q;
        word_count_d = word_count_q;
        case (state_q)
            ST_IDLE:    state_d = i_start ? ST_CLEAR : ST_IDLE;
            ST_CLEAR: begin
                state_d      = ST_RECEIVE;
                word_count_d = '0;
            end
            ST_RECEIVE: state_d = (shift && last_byte) ? ST_WRITE : ST_RECEIVE;
            ST_WRITE: begin
                word_count_d = word_count_inc;
                state_d      = (word == WW'(INSTRUCTION_HALT))              ? ST_DONE  :
                               (word_count_inc == CW'(MEM_SIZE_IN_WORDS))  ? ST_ERROR :
                                                                              ST_RECEIVE;
            end
            ST_DONE:    state_d = i_start ? ST_CLEAR : ST_DONE;
            ST_ERROR:   state_d = i_start ? ST_CLEAR : ST_ERROR;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Moore outputs decoded from the state register
    always_comb begin
        o_byte_ready        = (state_q == ST_RECEIVE);
        o_clear             = (state_q == ST_CLEAR);
        o_instruction_write = (state_q == ST_WRITE);
        o_done              = (state_q == ST_DONE);
        o_overflow          = (state_q == ST_ERROR);
    end

endmodule

// File: tb/tb_instruction_loader.sv
// tb_instruction_loader: directed scoreboard bench for the instruction loader
module tb_instruction_loader;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_start = 1'b0;
    logic        i_byte_valid = 1'b0;
    logic [7:0]  i_byte = 8'h00;
    logic        o_byte_ready;
    logic        o_clear;
    logic        o_instruction_write;
    logic [31:0] o_instruction;
    logic [3:0]  o_word_count;
    logic        o_done;
    logic        o_overflow;

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_wr  = 0;
    int          w0;
    logic [31:0] exp_q[$];

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    instruction_loader dut (
        .i_clk              (i_clk),
        .i_reset            (i_reset),
        .i_start            (i_start),
        .i_byte_valid       (i_byte_valid),
        .i_byte             (i_byte),
        .o_byte_ready       (o_byte_ready),
        .o_clear            (o_clear),
        .o_instruction_write(o_instruction_write),
        .o_instruction      (o_instruction),
        .o_word_count       (o_word_count),
        .o_done             (o_done),
        .o_overflow         (o_overflow)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // advance one clock, sample just after the edge, and score any write
    task automatic step();
        @(posedge i_clk);
        #1;
        if (o_instruction_write) begin
            n_wr++;
            if (exp_q.size() == 0) check("write_unexpected", 32'(o_instruction_write), 32'd0);
            else check("write_word", o_instruction, exp_q.pop_front());
        end
        check("clear_write_exclusive", 32'(o_clear & o_instruction_write), 32'd0);
    endtask

    task automatic do_reset(input int n);
        i_reset = 1'b1;
        repeat (n) step();
        i_reset = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic acc;
        int   gap;
        gap = int'($urandom_range(0, 2));
        repeat (gap) step();
        i_byte       = b;
        i_byte_valid = 1'b1;
        acc          = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) begin
            acc = o_byte_ready;
            step();
        end
        i_byte_valid = 1'b0;
        check("byte_accepted", 32'(acc), 32'd1);
    endtask

    task automatic send_word(input logic [31:0] w);
        exp_q.push_back(w);
        for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8]);
        check("write_latency", 32'(o_instruction_write), 32'd1);
    endtask

    task automatic start_load();
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        check("clear_pulse", 32'(o_clear), 32'd1);
        check("clear_done_low", 32'(o_done), 32'd0);
        step();
        check("clear_one_cycle", 32'(o_clear), 32'd0);
        check("count_zero_after_clear", 32'(o_word_count), 32'd0);
    endtask

    initial begin
        do_reset(3);
        check("rst_byte_ready", 32'(o_byte_ready), 32'd0);
        check("rst_clear", 32'(o_clear), 32'd0);
        check("rst_write", 32'(o_instruction_write), 32'd0);
        check("rst_instr", o_instruction, 32'd0);
        check("rst_count", 32'(o_word_count), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_overflow", 32'(o_overflow), 32'd0);
        i_byte = 8'h55;
        i_byte_valid = 1'b1;
        repeat (3) step();
        i_byte_valid = 1'b0;
        check("idle_byte_ready", 32'(o_byte_ready), 32'd0);
        check("idle_count", 32'(o_word_count), 32'd0);
        check("idle_no_write", 32'(n_wr), 32'd0);

        start_load();
        send_word(32'h1234_5678);
        check("single_instr", o_instruction, 32'h1234_5678);
        step();
        check("single_count", 32'(o_word_count), 32'd1);
        check("single_ready", 32'(o_byte_ready), 32'd1);
        check("single_instr_hold", o_instruction, 32'h1234_5678);
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        check("start_ignored_clear", 32'(o_clear), 32'd0);
        step();
        check("start_ignored_count", 32'(o_word_count), 32'd1);
        check("start_ignored_ready", 32'(o_byte_ready), 32'd1);

        do_reset(1);
        w0 = n_wr;
        start_load();
        send_word(32'hDEAD_BEEF);
        send_word(32'h0000_0001);
        send_word(HALT);
        step();
        check("halt_writes", 32'(n_wr - w0), 32'd3);
        check("halt_done", 32'(o_done), 32'd1);
        check("halt_count", 32'(o_word_count), 32'd3);
        i_byte = 8'hA5;
        i_byte_valid = 1'b1;
        repeat (8) begin
            step();
            check("done_ready_low", 32'(o_byte_ready), 32'd0);
        end
        i_byte_valid = 1'b0;
        check("done_no_extra_write", 32'(n_wr - w0), 32'd3);

        start_load();
        w0 = n_wr;
        for (int i = 0; i < 10; i++) send_word(32'hA000_0000 + 32'(i));
        step();
        check("ovf_writes", 32'(n_wr - w0), 32'd10);
        check("ovf_flag", 32'(o_overflow), 32'd1);
        check("ovf_done_low", 32'(o_done), 32'd0);
        check("ovf_count", 32'(o_word_count), 32'd10);
        i_byte = 8'h3C;
        i_byte_valid = 1'b1;
        repeat (10) step();
        i_byte_valid = 1'b0;
        check("ovf_no_11th_write", 32'(n_wr - w0), 32'd10);
        check("ovf_ready_low", 32'(o_byte_ready), 32'd0);

        start_load();
        check("restart_ovf_low", 32'(o_overflow), 32'd0);
        w0 = n_wr;
        for (int i = 0; i < 9; i++) send_word(32'h0B00_0000 + 32'(i));
        send_word(HALT);
        step();
        check("fullhalt_writes", 32'(n_wr - w0), 32'd10);
        check("fullhalt_done", 32'(o_done), 32'd1);
        check("fullhalt_overflow", 32'(o_overflow), 32'd0);
        check("fullhalt_count", 32'(o_word_count), 32'd10);

        start_load();
        send_byte(8'hAA);
        send_byte(8'hBB);
        do_reset(1);
        check("midrst_ready", 32'(o_byte_ready), 32'd0);
        check("midrst_count", 32'(o_word_count), 32'd0);
        w0 = n_wr;
        start_load();
        send_word(32'h0102_0304);
        step();
        check("midrst_writes", 32'(n_wr - w0), 32'd1);
        check("midrst_count_after", 32'(o_word_count), 32'd1);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
